// File: rtl/ppwm_pkg.sv
// Shared definitions for the PWM configuration path: serial-transmitter state
// type and the word width common to the transmitter and the PWM core.
package ppwm_pkg;

    localparam int PPWM_WORD_WIDTH = 10;

    // Phase counter width; covers HALF_PERIOD-1 for HALF_PERIOD up to 255.
    localparam int PHASE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_GUARD = 2'd3
    } ppwm_state_e;

endpackage

// File: rtl/ppwm_tick.sv
// Loadable phase down-counter: holds at zero and flags terminal count so the
// owner decides when to reload (every state change).
module ppwm_tick
    import ppwm_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [PHASE_W-1:0] load_val,
    output logic               tc
);

    logic [PHASE_W-1:0] count;

    // NOTE: non-blocking assignments for every register so all flops sample
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/ppwm_cfg_tx.sv
// Serial configuration transmitter for the PWM core: shifts a parallel word out
// MSB first on data_o with clk_data_o, data stable across each clock high phase.
module ppwm_cfg_tx
    import ppwm_pkg::*;
#(
    parameter int WORD_WIDTH  = PPWM_WORD_WIDTH,
    parameter int HALF_PERIOD = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] word_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  data_o,
    output logic                  clk_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    ppwm_state_e           state;
    logic [WORD_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  accept;
    logic                  phase_load;
    logic                  phase_tc;

    assign accept     = (state == ST_IDLE) && valid_i;
    // Transitions out of SETUP/HIGH/GUARD happen only on terminal count, so
    // reloading there is exactly "reload on every state change".
    assign phase_load = accept || ((state != ST_IDLE) && phase_tc);

    ppwm_tick u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (phase_load),
        .load_val (PHASE_W'(HALF_PERIOD - 1)),
        .tc       (phase_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            ready_o    <= 1'b1;
            data_o     <= 1'b0;
            clk_data_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_SETUP;
                        shift_reg <= word_i;
                        bit_cnt   <= CNT_W'(WORD_WIDTH - 1);
                        data_o    <= word_i[WORD_WIDTH-1];
                        busy_o    <= 1'b1;
                        ready_o   <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (phase_tc) begin
                        state      <= ST_HIGH;
                        clk_data_o <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (phase_tc) begin
                        clk_data_o <= 1'b0;
                        if (bit_cnt != '0) begin
                            // Next bit appears together with the clock fall.
                            state     <= ST_SETUP;
                            shift_reg <= {shift_reg[WORD_WIDTH-2:0], 1'b0};
                            bit_cnt   <= bit_cnt - 1'b1;
                            data_o    <= shift_reg[WORD_WIDTH-2];
                        end else begin
                            state  <= ST_GUARD;
                            data_o <= 1'b0;
                        end
                    end
                end
                ST_GUARD: begin
                    if (phase_tc) begin
                        state   <= ST_IDLE;
                        busy_o  <= 1'b0;
                        ready_o <= 1'b1;
                        done_o  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppwm_cfg_tx.sv
// Scoreboard bench for ppwm_cfg_tx: a driver predicts acceptance and completion
// from the transfer-length rule; a monitor checks every bit, edge and done pulse.
module tb_ppwm_cfg_tx;
    import ppwm_pkg::*;

    localparam int W    = PPWM_WORD_WIDTH;
    localparam int HP   = 4;
    localparam int XFER = (2 * W + 1) * HP;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] word_i = '0;
    logic         valid_i = 1'b0;
    logic         ready_o, data_o, clk_data_o, busy_o, done_o;

    logic [W-1:0] word2 = '0;
    logic         valid2 = 1'b0;
    logic         ready2, data2, clkd2, busy2, done2;

    ppwm_cfg_tx #(.WORD_WIDTH(W), .HALF_PERIOD(HP)) dut (
        .clk(clk), .rst_n(rst_n), .word_i(word_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_o(data_o), .clk_data_o(clk_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    ppwm_cfg_tx #(.WORD_WIDTH(W), .HALF_PERIOD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .word_i(word2), .valid_i(valid2),
        .ready_o(ready2), .data_o(data2), .clk_data_o(clkd2),
        .busy_o(busy2), .done_o(done2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] word;
        int           done_cyc;
    } pkt_t;

    pkt_t sb[$];
    int   head_bits  = 0;
    int   ready_from = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, mid-cycle.
    logic prev_clkd = 1'b0;
    logic prev_data = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            automatic int exp_rdy = (cyc >= ready_from) ? 1 : 0;
            check("ready_o", int'(ready_o), exp_rdy);
            check("busy_o", int'(busy_o), 1 - exp_rdy);
            if (exp_rdy == 1) begin
                check("idle data_o", int'(data_o), 0);
                check("idle clk_data_o", int'(clk_data_o), 0);
            end
            if (clk_data_o && prev_clkd)
                check("data_o stable while clk_data_o high", int'(data_o), int'(prev_data));
            if (clk_data_o && !prev_clkd) begin
                check("clk_data_o rise has pending word", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    check("clk_data_o rises within word", int'(head_bits < W), 1);
                    if (head_bits < W)
                        check("data_o at clk_data_o rise", int'(data_o),
                              int'(sb[0].word[W-1-head_bits]));
                    head_bits++;
                end
            end
            if (sb.size() != 0 && cyc == sb[0].done_cyc) begin
                check("done_o at expected cycle", int'(done_o), 1);
                check("bits sent before done_o", head_bits, W);
                void'(sb.pop_front());
                head_bits = 0;
            end else begin
                check("done_o outside completion", int'(done_o), 0);
            end
        end
        prev_clkd = clk_data_o;
        prev_data = data_o;
    end

    // Called #1 into a cycle; returns #1 into the first cycle after reset.
    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        sb.delete();
        head_bits = 0;
        repeat (n) @(posedge clk);
        #1;
        ready_from = cyc;
        check("reset ready_o", int'(ready_o), 1);
        check("reset data_o", int'(data_o), 0);
        check("reset clk_data_o", int'(clk_data_o), 0);
        check("reset busy_o", int'(busy_o), 0);
        check("reset done_o", int'(done_o), 0);
        rst_n = 1'b1;
    endtask

    // Holds valid until the model says the word is taken; returns in the
    // first SETUP cycle of that word.
    task automatic send(input logic [W-1:0] w);
        automatic int nd;
        word_i  = w;
        valid_i = 1'b1;
        while (cyc < ready_from) begin
            @(posedge clk);
            #1;
        end
        nd = cyc + 1 + XFER;
        sb.push_back('{word: w, done_cyc: nd});
        @(posedge clk);
        #1;
        ready_from = nd;
        valid_i    = 1'b0;
        word_i     = W'($urandom);
    endtask

    task automatic wait_idle();
        while (cyc < ready_from) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_while_busy(input int after);
        repeat (after) @(posedge clk);
        #1;
        valid_i = 1'b1;
        word_i  = W'($urandom);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic mid_reset(input int after);
        repeat (after) @(posedge clk);
        #1;
        apply_reset(1);
    endtask

    // HALF_PERIOD=2 instance, all-ones word.
    task automatic run_hp2();
        automatic int   rises = 0, ones = 0, last_rise = -1, bad_period = 0;
        automatic int   done_at = -1, c0;
        automatic logic prev = 1'b0;
        check("hp2 ready before send", int'(ready2), 1);
        word2  = '1;
        valid2 = 1'b1;
        @(posedge clk);
        #1;
        c0     = cyc - 1;
        valid2 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (clkd2 && !prev) begin
                rises++;
                ones += int'(data2);
                if (last_rise >= 0 && cyc - last_rise != 4) bad_period++;
                last_rise = cyc;
            end
            if (busy2 && !data2 && !(cyc >= c0 + 1 + 2 * W * 2)) ones -= 100;
            if (done2) done_at = cyc - c0;
            prev = clkd2;
            @(posedge clk);
            #1;
        end
        check("hp2 clk_data_o rises", rises, W);
        check("hp2 data_o high at rises/throughout", ones, W);
        check("hp2 clk_data_o period violations", bad_period, 0);
        check("hp2 done_o cycle", done_at, 43);
    endtask

    initial begin
        #1;
        apply_reset(2);

        // Directed: reference word, then back-to-back pair with valid held.
        send(W'(10'h2A5));
        wait_idle();
        send(W'(10'h200));
        send(W'(10'h3FF));
        wait_idle();

        // valid_i pulsed mid-transfer must be ignored.
        send(W'($urandom));
        pulse_while_busy(20);
        wait_idle();

        // Reset at cycle 30 of a transfer, then a clean word.
        send(W'(10'h155));
        mid_reset(29);
        send(W'(10'h0F0));
        wait_idle();

        // valid_i held through reset is taken only after release.
        word_i  = W'(10'h301);
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        apply_reset(3);
        send(W'(10'h301));
        wait_idle();

        run_hp2();

        for (int i = 0; i < 14; i++) begin
            automatic int choice = int'($urandom_range(0, 5));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(W'($urandom));
            if (choice == 0) pulse_while_busy(int'($urandom_range(1, XFER - 4)));
            if (choice == 1) mid_reset(int'($urandom_range(1, XFER - 2)));
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
